// File: rtl/core_bus_bridge.sv
// core_bus_bridge: arbitrates the core fetch and load/store ports onto one valid/ready
// memory bus, with wait-state stall requests, bus-timeout abort and flush discard.
module core_bus_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_data_o,
    output logic                if_ready_o,
    output logic                if_err_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_ready_o,
    output logic                mem_err_o,
    input  logic                pipe_stall_i,
    input  logic                flush_i,
    output logic                stallreq_o,
    output logic                bus_valid_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic                bus_ready_i,
    input  logic [DATA_W-1:0]   bus_rdata_i
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic               sel_mem;
    logic               discard;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  resp_data;
    logic               resp_err;

    logic if_pend;
    logic mem_pend;
    logic advance;
    logic port_req;
    logic timeout_hit;

    // A port is pending while it requests and has not yet been served this pipeline step
    assign if_pend     = if_req_i & ~if_ready_o;
    assign mem_pend    = mem_req_i & ~mem_ready_o;
    assign stallreq_o  = if_pend | mem_pend;
    assign advance     = ~stallreq_o & ~pipe_stall_i;
    assign port_req    = sel_mem ? mem_req_i : if_req_i;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sel_mem     <= 1'b0;
            discard     <= 1'b0;
            cnt         <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            if_data_o   <= '0;
            if_ready_o  <= 1'b0;
            if_err_o    <= 1'b0;
            mem_rdata_o <= '0;
            mem_ready_o <= 1'b0;
            mem_err_o   <= 1'b0;
            bus_valid_o <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
        end else begin
            // Served flags live until the pipeline moves on or is flushed
            if (flush_i || advance) begin
                if_ready_o  <= 1'b0;
                if_err_o    <= 1'b0;
                mem_ready_o <= 1'b0;
                mem_err_o   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!flush_i && (mem_pend || if_pend)) begin
                        state       <= BUSY;
                        bus_valid_o <= 1'b1;
                        discard     <= 1'b0;
                        cnt         <= '0;
                        sel_mem     <= mem_pend;
                        if (mem_pend) begin
                            bus_we_o    <= mem_we_i;
                            bus_sel_o   <= mem_sel_i;
                            bus_addr_o  <= mem_addr_i;
                            bus_wdata_o <= mem_wdata_i;
                        end else begin
                            bus_we_o    <= 1'b0;
                            bus_sel_o   <= {SEL_W{1'b1}};
                            bus_addr_o  <= if_addr_i;
                            bus_wdata_o <= '0;
                        end
                    end
                end
                BUSY: begin
                    // The bus handshake always finishes; only the result is dropped
                    if (flush_i || !port_req) begin
                        discard <= 1'b1;
                    end
                    if (bus_ready_i) begin
                        bus_valid_o <= 1'b0;
                        resp_data   <= bus_we_o ? '0 : bus_rdata_i;
                        resp_err    <= 1'b0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        bus_valid_o <= 1'b0;
                        resp_data   <= '0;
                        resp_err    <= 1'b1;
                        state       <= RESP;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (!discard && !flush_i) begin
                        if (sel_mem) begin
                            mem_ready_o <= 1'b1;
                            mem_rdata_o <= resp_data;
                            mem_err_o   <= resp_err;
                        end else begin
                            if_ready_o <= 1'b1;
                            if_data_o  <= resp_data;
                            if_err_o   <= resp_err;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
